data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/data_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the load/store unit and the data memory controller.
interface data_mem_ctrl_if #(
   parameter int unsigned BUS_WIDTH = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [31:0]          req_addr;
   logic [BUS_WIDTH-1:0] req_wdata;
   logic [1:0]           req_size;
   logic                 req_unsigned;
   logic                 rsp_valid;
   logic [BUS_WIDTH-1:0] rsp_rdata;
   logic                 rsp_error;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Handshaked byte-enable data memory: lane steering, load extension,
// programmable wait states and registered error responses.
module data_mem_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 15,
   parameter int unsigned BUS_WIDTH   = 32,
   parameter int unsigned WAIT_STATES = 0,
   parameter string       INIT_FILE   = ""
) (
   input  logic            clk,
   input  logic            rst_n,
   data_mem_ctrl_if.slave  bus
);
   localparam int unsigned LANES    = BUS_WIDTH / 8;
   localparam int unsigned OFF_W    = $clog2(LANES);
   localparam int unsigned ROW_W    = ADDR_WIDTH - OFF_W;
   localparam int unsigned DEPTH    = 2 ** ROW_W;
   localparam int unsigned MAX_ADDR = (2 ** ADDR_WIDTH) - 1;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic                   we_q;
   logic [BUS_WIDTH-1:0]   wdata_q;
   logic [1:0]             size_q;
   logic                   uns_q;

   logic                   req_err_c;
   logic [OFF_W-1:0]       off_c;
   logic [ROW_W-1:0]       row_c;
   logic [LANES-1:0]       be_c;
   logic [BUS_WIDTH-1:0]   wr_data_c;
   logic [BUS_WIDTH-1:0]   rd_row_c;
   logic [BUS_WIDTH-1:0]   rd_shift_c;
   logic [BUS_WIDTH-1:0]   keep_c;
   logic                   sign_c;
   logic [BUS_WIDTH-1:0]   load_c;

   logic [BUS_WIDTH-1:0]   mem [DEPTH];

   // Fault decode on the live request, evaluated at acceptance.
   always_comb begin
      req_err_c = 1'b0;
      if (bus.req_addr > 32'(MAX_ADDR)) req_err_c = 1'b1;
      case (bus.req_size)
         2'b01:   if (bus.req_addr[0]) req_err_c = 1'b1;
         2'b10:   if (bus.req_addr[1:0] != 2'b00) req_err_c = 1'b1;
         2'b11:   if ((BUS_WIDTH == 32) || (bus.req_addr[2:0] != 3'b000)) req_err_c = 1'b1;
         default: ;
      endcase
   end

   // Store lane steering and load alignment from the registered request.
   always_comb begin
      off_c = addr_q[OFF_W-1:0];
      row_c = addr_q[ADDR_WIDTH-1:OFF_W];
      case (size_q)
         2'b00:   be_c = LANES'(1);
         2'b01:   be_c = LANES'(3);
         2'b10:   be_c = LANES'(15);
         default: be_c = '1;
      endcase
      be_c       = be_c << off_c;
      wr_data_c  = wdata_q << {off_c, 3'b000};
      rd_row_c   = mem[row_c];
      rd_shift_c = rd_row_c >> {off_c, 3'b000};
      case (size_q)
         2'b00:   begin keep_c = BUS_WIDTH'(8'hFF);         sign_c = rd_shift_c[7];  end
         2'b01:   begin keep_c = BUS_WIDTH'(16'hFFFF);      sign_c = rd_shift_c[15]; end
         2'b10:   begin keep_c = BUS_WIDTH'(32'hFFFF_FFFF); sign_c = rd_shift_c[31]; end
         default: begin keep_c = '1; sign_c = rd_shift_c[BUS_WIDTH-1]; end
      endcase
      load_c = (rd_shift_c & keep_c) | ((sign_c && !uns_q) ? ~keep_c : '0);
   end

   // RAM write port: only ACCESS with a non-faulting store reaches here.
   always_ff @(posedge clk) begin
      if ((state == S_ACCESS) && we_q) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (be_c[i]) mem[row_c][8*i +: 8] <= wr_data_c[8*i +: 8];
         end
      end
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         addr_q        <= '0;
         we_q          <= 1'b0;
         wdata_q       <= '0;
         size_q        <= '0;
         uns_q         <= 1'b0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_error <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  addr_q        <= bus.req_addr[ADDR_WIDTH-1:0];
                  we_q          <= bus.req_we;
                  wdata_q       <= bus.req_wdata;
                  size_q        <= bus.req_size;
                  uns_q         <= bus.req_unsigned;
                  bus.req_ready <= 1'b0;
                  if (req_err_c) begin
                     state         <= S_RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_error <= 1'b1;
                     bus.rsp_rdata <= '0;
                  end else if (WAIT_STATES > 0) begin
                     state <= S_WAIT;
                     cnt   <= CNT_W'(WAIT_STATES - 1);
                  end else begin
                     state <= S_ACCESS;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == '0) state <= S_ACCESS;
               else           cnt   <= cnt - CNT_W'(1);
            end
            S_ACCESS: begin
               state         <= S_RESP;
               bus.rsp_valid <= 1'b1;
               bus.rsp_error <= 1'b0;
               bus.rsp_rdata <= we_q ? '0 : load_c;
            end
            S_RESP: begin
               state         <= S_IDLE;
               bus.req_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three configurations checked against a byte-array reference.
module tb_data_mem_ctrl;
   logic clk;
   logic rst_n;

   data_mem_ctrl_if #(.BUS_WIDTH(32)) if32 ();
   data_mem_ctrl_if #(.BUS_WIDTH(32)) ifw  ();
   data_mem_ctrl_if #(.BUS_WIDTH(64)) if64 ();

   data_mem_ctrl #(.ADDR_WIDTH(15), .BUS_WIDTH(32), .WAIT_STATES(0), .INIT_FILE(""))
      u_d32 (.clk(clk), .rst_n(rst_n), .bus(if32));
   data_mem_ctrl #(.ADDR_WIDTH(15), .BUS_WIDTH(32), .WAIT_STATES(3), .INIT_FILE(""))
      u_dws (.clk(clk), .rst_n(rst_n), .bus(ifw));
   data_mem_ctrl #(.ADDR_WIDTH(15), .BUS_WIDTH(64), .WAIT_STATES(1), .INIT_FILE(""))
      u_d64 (.clk(clk), .rst_n(rst_n), .bus(if64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   bit   [7:0] mb [3][32768];
   bit         mk [3][32768];
   logic [63:0] last_rdata;
   logic        last_err;
   int          acc_q[$];
   int          rsp_q[$];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 3 : 1);
   endfunction

   task automatic drive(input int d, input bit v, input bit we, input logic [31:0] a,
                        input logic [63:0] wd, input logic [1:0] sz, input bit u);
      case (d)
         0: begin if32.req_valid = v; if32.req_we = we; if32.req_addr = a;
                  if32.req_wdata = wd[31:0]; if32.req_size = sz; if32.req_unsigned = u; end
         1: begin ifw.req_valid = v; ifw.req_we = we; ifw.req_addr = a;
                  ifw.req_wdata = wd[31:0]; ifw.req_size = sz; ifw.req_unsigned = u; end
         default: begin if64.req_valid = v; if64.req_we = we; if64.req_addr = a;
                  if64.req_wdata = wd; if64.req_size = sz; if64.req_unsigned = u; end
      endcase
   endtask

   function automatic logic get_ready(input int d);
      return (d == 0) ? if32.req_ready : ((d == 1) ? ifw.req_ready : if64.req_ready);
   endfunction
   function automatic logic get_valid(input int d);
      return (d == 0) ? if32.rsp_valid : ((d == 1) ? ifw.rsp_valid : if64.rsp_valid);
   endfunction
   function automatic logic get_err(input int d);
      return (d == 0) ? if32.rsp_error : ((d == 1) ? ifw.rsp_error : if64.rsp_error);
   endfunction
   function automatic logic [63:0] get_rdata(input int d);
      return (d == 0) ? 64'(if32.rsp_rdata) : ((d == 1) ? 64'(ifw.rsp_rdata) : if64.rsp_rdata);
   endfunction

   // Reference: byte-addressed memory, natural alignment, plain arithmetic extension.
   task automatic model(input int d, input bit we, input logic [31:0] a, input logic [63:0] wd,
                        input logic [1:0] sz, input bit u,
                        output bit e, output logic [63:0] rd, output int lat, output bit kn);
      int nb = 1 << sz;
      int bw = (d == 2) ? 64 : 32;
      e  = (a > 32'h7FFF) || (sz == 2'b11 && bw == 32) || ((a % nb) != 0);
      rd = '0;
      kn = 1'b1;
      if (e) begin
         lat = 1;
      end else begin
         lat = 2 + ws_of(d);
         for (int i = 0; i < nb; i++) begin
            if (we) begin
               mb[d][a+i] = wd[8*i +: 8];
               mk[d][a+i] = 1'b1;
            end else begin
               rd = rd | (64'(mb[d][a+i]) << (8*i));
               kn = kn & mk[d][a+i];
            end
         end
         if (!we && !u && rd[8*nb-1]) rd = rd | ~((64'd1 << (8*nb)) - 64'd1);
         if (bw == 32) rd = rd & 64'hFFFF_FFFF;
      end
   endtask

   task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [63:0] wd,
                      input logic [1:0] sz, input bit u);
      bit e, kn;
      logic [63:0] rd;
      int lat, n, g;
      bit seen;
      model(d, we, a, wd, sz, u, e, rd, lat, kn);
      drive(d, 1'b1, we, a, wd, sz, u);
      g = 0;
      while (!get_ready(d) && g < 20) begin @(negedge clk); g++; end
      check("ready_at_req", 64'(get_ready(d)), 64'd1);
      @(posedge clk);
      #1 drive(d, 1'b0, 1'($urandom), $urandom, {$urandom, $urandom}, 2'($urandom), 1'($urandom));
      n = 0; seen = 1'b0;
      while (!seen && n < 30) begin
         @(negedge clk);
         n++;
         if (get_valid(d)) seen = 1'b1;
      end
      check("latency", 64'(n), 64'(lat));
      check("rsp_error", 64'(get_err(d)), 64'(e));
      if (kn) check("rsp_rdata", get_rdata(d), rd);
      last_rdata = get_rdata(d);
      last_err   = get_err(d);
      @(negedge clk);
      check("pulse_ready", {62'd0, get_valid(d), get_ready(d)}, 64'b01);
   endtask

   initial begin
      int bad;
      bit e, kn;
      logic [63:0] rd;
      int lat;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      #12;
      for (int d = 0; d < 3; d += 2) begin
         check("rst_valid", 64'(get_valid(d)), 64'd0);
         check("rst_error", 64'(get_err(d)), 64'd0);
         check("rst_rdata", get_rdata(d), 64'd0);
         check("rst_ready", 64'(get_ready(d)), 64'd1);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // 32-bit, no wait states
      txn(0, 1'b1, 32'h100, 64'hDEADBEEF, 2'b10, 1'b0);
      txn(0, 1'b0, 32'h100, 64'h0, 2'b10, 1'b0);
      check("w_load", last_rdata, 64'hDEADBEEF);
      txn(0, 1'b1, 32'h103, 64'h80, 2'b00, 1'b0);
      txn(0, 1'b0, 32'h103, 64'h0, 2'b00, 1'b0);
      check("b_signed", last_rdata, 64'hFFFFFF80);
      txn(0, 1'b0, 32'h103, 64'h0, 2'b00, 1'b1);
      check("b_unsigned", last_rdata, 64'h80);
      txn(0, 1'b0, 32'h100, 64'h0, 2'b10, 1'b0);
      check("w_merged", last_rdata, 64'h80ADBEEF);
      txn(0, 1'b0, 32'h101, 64'h0, 2'b01, 1'b0);
      check("err_half", {63'd0, last_err}, 64'd1);
      txn(0, 1'b1, 32'h102, 64'hCAFEF00D, 2'b10, 1'b0);
      check("err_word_st", {63'd0, last_err}, 64'd1);
      txn(0, 1'b0, 32'h8000, 64'h0, 2'b10, 1'b0);
      check("err_range", {63'd0, last_err}, 64'd1);
      txn(0, 1'b0, 32'h100, 64'h0, 2'b10, 1'b0);
      check("w_after_err", last_rdata, 64'h80ADBEEF);

      // 64-bit bus
      txn(2, 1'b1, 32'h10, 64'h0123456789ABCDEF, 2'b11, 1'b0);
      txn(2, 1'b0, 32'h14, 64'h0, 2'b10, 1'b0);
      check("d64_w_hi", last_rdata, 64'h0000000001234567);
      txn(2, 1'b0, 32'h10, 64'h0, 2'b10, 1'b0);
      check("d64_w_lo", last_rdata, 64'hFFFFFFFF89ABCDEF);
      txn(2, 1'b0, 32'h12, 64'h0, 2'b11, 1'b0);
      check("d64_err", {63'd0, last_err}, 64'd1);
      txn(2, 1'b0, 32'h10, 64'h0, 2'b11, 1'b0);
      check("d64_dbl", last_rdata, 64'h0123456789ABCDEF);

      // Wait states with req_valid held high
      txn(1, 1'b1, 32'h40, 64'h87654321, 2'b10, 1'b0);
      drive(1, 1'b1, 1'b0, 32'h40, 64'h0, 2'b10, 1'b0);
      for (int k = 0; k < 20; k++) begin
         if (get_ready(1)) acc_q.push_back(k);
         if (get_valid(1)) begin
            rsp_q.push_back(k);
            check("ws_rdata", get_rdata(1), 64'h87654321);
         end
         @(negedge clk);
      end
      drive(1, 1'b0, 1'b0, 32'h40, 64'h0, 2'b10, 1'b0);
      repeat (8) @(negedge clk);
      check("ws_n_acc", 64'(acc_q.size()), 64'd4);
      check("ws_n_rsp", 64'(rsp_q.size()), 64'd3);
      for (int i = 1; i < acc_q.size(); i++) check("ws_gap", 64'(acc_q[i] - acc_q[i-1]), 64'd6);
      for (int i = 0; i < rsp_q.size() && i < acc_q.size(); i++)
         check("ws_lat", 64'(rsp_q[i] - acc_q[i]), 64'd5);

      // Reset before the ACCESS edge: write must not happen
      txn(0, 1'b1, 32'h200, 64'h11223344, 2'b10, 1'b0);
      drive(0, 1'b1, 1'b1, 32'h200, 64'h55667788, 2'b10, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      @(negedge clk); rst_n = 1'b0;
      #1 check("rst_mid_ready", 64'(get_ready(0)), 64'd1);
      @(negedge clk); rst_n = 1'b1;
      bad = 0;
      repeat (5) begin @(negedge clk); if (get_valid(0)) bad++; end
      check("rst_no_rsp", 64'(bad), 64'd0);
      txn(0, 1'b0, 32'h200, 64'h0, 2'b10, 1'b0);
      check("rst_old_val", last_rdata, 64'h11223344);

      // Reset right after the ACCESS edge: write is committed
      drive(0, 1'b1, 1'b1, 32'h200, 64'h99AABBCC, 2'b10, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      model(0, 1'b1, 32'h200, 64'h99AABBCC, 2'b10, 1'b0, e, rd, lat, kn);
      @(negedge clk);
      check("rst_resp_kill", 64'(get_valid(0)), 64'd0);
      rst_n = 1'b1;
      bad = 0;
      repeat (5) begin @(negedge clk); if (get_valid(0)) bad++; end
      check("rst2_no_rsp", 64'(bad), 64'd0);
      txn(0, 1'b0, 32'h200, 64'h0, 2'b10, 1'b0);
      check("rst_new_val", last_rdata, 64'h99AABBCC);

      // Randomised: fill two windows, then mixed traffic including faults
      for (int d = 0; d < 3; d++) begin
         int step = (d == 2) ? 8 : 4;
         for (int w = 0; w < 2; w++)
            for (int o = 0; o < 256; o += step)
               txn(d, 1'b1, ((w == 0) ? 32'h0 : 32'h7F00) + 32'(o), {$urandom, $urandom},
                   (d == 2) ? 2'b11 : 2'b10, 1'b0);
         for (int t = 0; t < 150; t++) begin
            int r = $urandom_range(0, 15);
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic [31:0] a;
            if (r == 0) a = $urandom | 32'h8000;
            else begin
               a = (r[0] ? 32'h7F00 : 32'h0) + 32'($urandom_range(0, 255));
               if (r > 4) a = a & ~((32'd1 << sz) - 32'd1);
            end
            txn(d, 1'($urandom), a, {$urandom, $urandom}, sz, 1'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
